// File: rtl/mem_pkg.sv
// Shared definitions for the instruction/data RAM access controller:
// default geometry, port B state encoding and the request address check.
package mem_pkg;

   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_ADDR_WIDTH = 32;
   localparam int DEF_MEM_WORDS  = 32;
   localparam int BE_W           = DEF_DATA_WIDTH / 8;
   localparam int WORD_IDX_W     = $clog2(DEF_MEM_WORDS);

   typedef enum logic {
      IDLE   = 1'b0,
      RMW_WR = 1'b1
   } b_state_t;

   // Byte address must be word aligned and its word index inside the RAM.
   function automatic logic addr_ok(input logic [63:0] addr, input int mem_words);
      return (addr[1:0] == 2'b00) && ((addr >> 2) < 64'(mem_words));
   endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Request/response and RAM-side signal bundle of the memory access controller.
interface mem_ctrl_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
);
   localparam int BEW = DATA_WIDTH / 8;

   logic                  ld_req;
   logic [ADDR_WIDTH-1:0] ld_addr;
   logic [DATA_WIDTH-1:0] ld_wdata;
   logic                  ld_gnt;

   logic                  i_req;
   logic [ADDR_WIDTH-1:0] i_addr;
   logic                  i_gnt;
   logic                  i_rvalid;
   logic [DATA_WIDTH-1:0] i_rdata;
   logic                  i_err;

   logic                  d_req;
   logic                  d_we;
   logic [BEW-1:0]        d_be;
   logic [ADDR_WIDTH-1:0] d_addr;
   logic [DATA_WIDTH-1:0] d_wdata;
   logic                  d_gnt;
   logic                  d_rvalid;
   logic [DATA_WIDTH-1:0] d_rdata;
   logic                  d_err;

   logic [ADDR_WIDTH-1:0] ram_addr_a, ram_addr_b;
   logic                  ram_we_a, ram_we_b;
   logic [DATA_WIDTH-1:0] ram_data_a, ram_data_b;
   logic [DATA_WIDTH-1:0] ram_q_a, ram_q_b;

   modport master (
      output ld_req, ld_addr, ld_wdata,
      output i_req, i_addr,
      output d_req, d_we, d_be, d_addr, d_wdata,
      input  ld_gnt, i_gnt, i_rvalid, i_rdata, i_err,
      input  d_gnt, d_rvalid, d_rdata, d_err
   );

   modport slave (
      input  ld_req, ld_addr, ld_wdata,
      input  i_req, i_addr,
      input  d_req, d_we, d_be, d_addr, d_wdata,
      output ld_gnt, i_gnt, i_rvalid, i_rdata, i_err,
      output d_gnt, d_rvalid, d_rdata, d_err,
      output ram_addr_a, ram_addr_b, ram_we_a, ram_we_b, ram_data_a, ram_data_b,
      input  ram_q_a, ram_q_b
   );

   modport ram (
      input  ram_addr_a, ram_addr_b, ram_we_a, ram_we_b, ram_data_a, ram_data_b,
      output ram_q_a, ram_q_b
   );

endinterface

// File: rtl/mem_ctrl_byte_merge.sv
// Per-byte select between the word read back from RAM and new store data.
module byte_merge #(
   parameter int DATA_WIDTH = 32
) (
   input  logic [DATA_WIDTH-1:0]   old_word,
   input  logic [DATA_WIDTH-1:0]   new_word,
   input  logic [DATA_WIDTH/8-1:0] be,
   output logic [DATA_WIDTH-1:0]   merged
);

   always_comb begin
      merged = old_word;
      for (int k = 0; k < DATA_WIDTH / 8; k++) begin
         if (be[k]) merged[8*k +: 8] = new_word[8*k +: 8];
      end
   end

endmodule

// File: rtl/mem_ctrl.sv
// Dual-port RAM access controller: loader/fetch arbitration on port A,
// load/store with read-modify-write byte stores on port B.
module mem_ctrl
   import mem_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int MEM_WORDS  = DEF_MEM_WORDS
) (
   input logic       clk,
   input logic       rst,
   mem_ctrl_if.slave bus
);

   localparam int BEW = DATA_WIDTH / 8;
   localparam logic [BEW-1:0] BE_ONES = '1;

   b_state_t              state_p1;
   logic [ADDR_WIDTH-1:0] rmw_addr_p1;
   logic [BEW-1:0]        rmw_be_p1;
   logic [DATA_WIDTH-1:0] rmw_wdata_p1;
   logic [DATA_WIDTH-1:0] merged;

   logic                  i_vld_p1, i_err_p1;
   logic                  d_vld_p1, d_err_p1, d_load_p1;

   logic                  ld_ok, i_ok, d_ok, in_rmw;
   logic                  d_full, d_part;
   logic                  ld_gnt, i_gnt, d_gnt, b_wr;
   logic [ADDR_WIDTH-1:0] b_addr;

   function automatic logic same_word(input logic [ADDR_WIDTH-1:0] a,
                                      input logic [ADDR_WIDTH-1:0] b);
      return a[ADDR_WIDTH-1:2] == b[ADDR_WIDTH-1:2];
   endfunction

   byte_merge #(.DATA_WIDTH(DATA_WIDTH)) u_merge (
      .old_word (bus.ram_q_b),
      .new_word (rmw_wdata_p1),
      .be       (rmw_be_p1),
      .merged   (merged)
   );

   // Grants are combinational; rst masks every grant and write enable so a
   // write in flight during reset never lands in the RAM.
   always_comb begin
      ld_ok  = addr_ok(64'(bus.ld_addr), MEM_WORDS);
      i_ok   = addr_ok(64'(bus.i_addr), MEM_WORDS);
      d_ok   = addr_ok(64'(bus.d_addr), MEM_WORDS);
      in_rmw = (state_p1 == RMW_WR);
      d_full = bus.d_we && d_ok && (bus.d_be == BE_ONES);
      d_part = bus.d_we && d_ok && (bus.d_be != '0) && (bus.d_be != BE_ONES);
      ld_gnt = !rst && bus.ld_req && !(in_rmw && same_word(bus.ld_addr, rmw_addr_p1));
      d_gnt  = !rst && !in_rmw && bus.d_req &&
               !(bus.ld_req && same_word(bus.ld_addr, bus.d_addr));
      b_addr = in_rmw ? rmw_addr_p1 : bus.d_addr;
      b_wr   = !rst && (in_rmw || (d_gnt && d_full));
      i_gnt  = !rst && bus.i_req && !bus.ld_req && !(b_wr && same_word(bus.i_addr, b_addr));
   end

   assign bus.ld_gnt     = ld_gnt;
   assign bus.i_gnt      = i_gnt;
   assign bus.d_gnt      = d_gnt;
   assign bus.ram_addr_a = bus.ld_req ? bus.ld_addr : bus.i_addr;
   assign bus.ram_we_a   = ld_gnt && ld_ok;
   assign bus.ram_data_a = bus.ld_wdata;
   assign bus.ram_addr_b = b_addr;
   assign bus.ram_we_b   = b_wr;
   assign bus.ram_data_b = in_rmw ? merged : bus.d_wdata;

   // Response stage: RAM read data arrives with the registered valid.
   assign bus.i_rvalid = i_vld_p1;
   assign bus.i_err    = i_err_p1;
   assign bus.i_rdata  = (i_vld_p1 && !i_err_p1) ? bus.ram_q_a : '0;
   assign bus.d_rvalid = d_vld_p1;
   assign bus.d_err    = d_err_p1;
   assign bus.d_rdata  = (d_vld_p1 && d_load_p1) ? bus.ram_q_b : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_p1     <= IDLE;
         rmw_addr_p1  <= '0;
         rmw_be_p1    <= '0;
         rmw_wdata_p1 <= '0;
         i_vld_p1     <= 1'b0;
         i_err_p1     <= 1'b0;
         d_vld_p1     <= 1'b0;
         d_err_p1     <= 1'b0;
         d_load_p1    <= 1'b0;
      end else begin
         i_vld_p1  <= i_gnt;
         i_err_p1  <= i_gnt && !i_ok;
         d_vld_p1  <= 1'b0;
         d_err_p1  <= 1'b0;
         d_load_p1 <= 1'b0;
         case (state_p1)
            IDLE: begin
               if (d_gnt) begin
                  if (d_part) begin
                     state_p1     <= RMW_WR;
                     rmw_addr_p1  <= bus.d_addr;
                     rmw_be_p1    <= bus.d_be;
                     rmw_wdata_p1 <= bus.d_wdata;
                  end else begin
                     d_vld_p1  <= 1'b1;
                     d_err_p1  <= !d_ok;
                     d_load_p1 <= d_ok && !bus.d_we;
                  end
               end
            end
            RMW_WR: begin
               state_p1 <= IDLE;
               d_vld_p1 <= 1'b1;
            end
            default: state_p1 <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed and randomized bench for mem_ctrl with a registered RAM model
// and a word-array reference of the expected memory contents.
module tb_mem_ctrl;
   import mem_pkg::*;

   localparam int DW = DEF_DATA_WIDTH;
   localparam int AW = DEF_ADDR_WIDTH;
   localparam int NW = DEF_MEM_WORDS;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mem_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   mem_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_WORDS(NW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Registered-read RAM, read-before-write.
   logic [DW-1:0] ram [NW];
   always @(posedge clk) begin
      if (bus.ram_we_a) ram[bus.ram_addr_a[2 +: WORD_IDX_W]] <= bus.ram_data_a;
      if (bus.ram_we_b) ram[bus.ram_addr_b[2 +: WORD_IDX_W]] <= bus.ram_data_b;
      bus.ram_q_a <= ram[bus.ram_addr_a[2 +: WORD_IDX_W]];
      bus.ram_q_b <= ram[bus.ram_addr_b[2 +: WORD_IDX_W]];
   end

   logic [DW-1:0]   model [NW];
   int              n_cmp = 0;
   int              n_bad = 0;
   logic [AW-1:0]   a, fa;
   logic [DW-1:0]   wd, v, v2;
   logic [BE_W-1:0] be;
   logic            we, fe;
   int              r;

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic a_ok(input logic [AW-1:0] addr);
      return (addr % 4 == 0) && (addr / 4 < NW);
   endfunction

   function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                           input logic [BE_W-1:0] bes);
      logic [DW-1:0] mask;
      mask = '0;
      for (int k = 0; k < BE_W; k++) if (bes[k]) mask = mask | (DW'(8'hFF) << (8 * k));
      return (old & ~mask) | (nw & mask);
   endfunction

   task automatic idle();
      bus.ld_req = 0; bus.ld_addr = '0; bus.ld_wdata = '0;
      bus.i_req = 0;  bus.i_addr = '0;
      bus.d_req = 0;  bus.d_we = 0; bus.d_be = '0; bus.d_addr = '0; bus.d_wdata = '0;
   endtask

   task automatic ld_write(input logic [AW-1:0] la, input logic [DW-1:0] lv);
      @(negedge clk);
      idle();
      bus.ld_req = 1; bus.ld_addr = la; bus.ld_wdata = lv;
      #1;
      chk("ld_gnt", bus.ld_gnt, 1);
      chk("ld_ram_we_a", bus.ram_we_a, a_ok(la));
      if (a_ok(la)) model[la / 4] = lv;
   endtask

   // One port B transaction, optionally with a concurrent fetch.
   task automatic do_data(input logic dwe, input logic [BE_W-1:0] dbe, input logic [AW-1:0] da,
                          input logic [DW-1:0] dwd, input logic dfe, input logic [AW-1:0] dfa);
      logic ok, full, part, fok, igt, fhold;
      logic [DW-1:0] old, fexp;
      ok    = a_ok(da);
      fok   = a_ok(dfa);
      full  = dwe && ok && dbe == '1;
      part  = dwe && ok && dbe != '0 && dbe != '1;
      igt   = dfe && !(full && (da / 4 == dfa / 4));
      fhold = dfe && !igt;
      old   = ok ? model[da / 4] : '0;
      fexp  = (dfe && fok) ? model[dfa / 4] : '0;
      @(negedge clk);
      idle();
      bus.d_req = 1; bus.d_we = dwe; bus.d_be = dbe; bus.d_addr = da; bus.d_wdata = dwd;
      bus.i_req = dfe; bus.i_addr = dfa;
      #1;
      chk("d_gnt", bus.d_gnt, 1);
      chk("i_gnt", bus.i_gnt, igt);
      chk("ram_we_b", bus.ram_we_b, full);
      if (full) model[da / 4] = dwd;
      if (part) model[da / 4] = merge(old, dwd, dbe);
      @(negedge clk);
      idle();
      bus.i_req = fhold; bus.i_addr = dfa;
      if (part) begin
         bus.d_req = 1; bus.d_we = 0; bus.d_addr = da;
      end
      #1;
      if (igt) begin
         chk("i_rvalid", bus.i_rvalid, 1);
         chk("i_err", bus.i_err, !fok);
         chk("i_rdata", bus.i_rdata, fexp);
      end
      if (part) begin
         chk("rmw_stall_gnt", bus.d_gnt, 0);
         chk("rmw_we_b", bus.ram_we_b, 1);
         chk("rmw_data_b", bus.ram_data_b, model[da / 4]);
         chk("rmw_no_ack", bus.d_rvalid, 0);
      end else begin
         chk("d_rvalid", bus.d_rvalid, 1);
         chk("d_err", bus.d_err, !ok);
         chk("d_rdata", bus.d_rdata, (!dwe && ok) ? old : '0);
      end
      if (fhold) chk("i_gnt_retry", bus.i_gnt, 1);
      if (part || fhold) begin
         @(negedge clk);
         idle();
         #1;
         if (part) begin
            chk("rmw_ack", bus.d_rvalid, 1);
            chk("rmw_err", bus.d_err, 0);
            chk("rmw_rdata", bus.d_rdata, 0);
         end
         if (fhold) begin
            chk("i_rvalid_retry", bus.i_rvalid, 1);
            chk("i_rdata_retry", bus.i_rdata, fok ? model[dfa / 4] : '0);
         end
      end
   endtask

   initial begin
      rst = 1;
      idle();
      // Reset: grants masked even with every request asserted.
      @(negedge clk);
      bus.ld_req = 1; bus.i_req = 1; bus.d_req = 1; bus.d_we = 1; bus.d_be = '1;
      #1;
      chk("rst_ld_gnt", bus.ld_gnt, 0);
      chk("rst_i_gnt", bus.i_gnt, 0);
      chk("rst_d_gnt", bus.d_gnt, 0);
      chk("rst_we_a", bus.ram_we_a, 0);
      chk("rst_we_b", bus.ram_we_b, 0);
      @(negedge clk);
      idle();
      #1;
      chk("rst_i_rvalid", bus.i_rvalid, 0);
      chk("rst_d_rvalid", bus.d_rvalid, 0);
      chk("rst_i_err", bus.i_err, 0);
      chk("rst_d_err", bus.d_err, 0);
      chk("rst_i_rdata", bus.i_rdata, 0);
      chk("rst_d_rdata", bus.d_rdata, 0);
      rst = 0;

      // Preload through the loader, plus two dropped erroring loader writes.
      for (int w = 0; w < NW; w++) begin
         case (w)
            0:       v = 32'h11111111;
            1:       v = 32'h22222222;
            2:       v = 32'h33333333;
            3:       v = 32'hDEADBEEF;
            4:       v = 32'hAABBCCDD;
            default: v = $urandom;
         endcase
         ld_write(AW'(w * 4), v);
      end
      ld_write(32'h81, 32'hFFFFFFFF);
      ld_write(32'h100, 32'hFFFFFFFF);

      // Back-to-back fetches.
      @(negedge clk); idle(); bus.i_req = 1; bus.i_addr = 32'h0; #1;
      chk("f0_gnt", bus.i_gnt, 1);
      @(negedge clk); bus.i_addr = 32'h4; #1;
      chk("f1_gnt", bus.i_gnt, 1);
      chk("f0_rvalid", bus.i_rvalid, 1);
      chk("f0_rdata", bus.i_rdata, 32'h11111111);
      chk("f0_err", bus.i_err, 0);
      @(negedge clk); bus.i_addr = 32'h8; #1;
      chk("f2_gnt", bus.i_gnt, 1);
      chk("f1_rdata", bus.i_rdata, 32'h22222222);
      @(negedge clk); idle(); #1;
      chk("f2_rvalid", bus.i_rvalid, 1);
      chk("f2_rdata", bus.i_rdata, 32'h33333333);

      // Partial store then load back.
      do_data(1, 4'b0101, 32'h10, 32'h11223344, 0, 32'h0);
      chk("rmw_word", ram[4], 32'hAA22CC44);
      do_data(0, 4'b0000, 32'h10, 32'h0, 0, 32'h0);

      // Loader beats fetch on port A.
      @(negedge clk); idle();
      bus.ld_req = 1; bus.ld_addr = 32'h20; bus.ld_wdata = 32'hCAFEF00D;
      bus.i_req = 1; bus.i_addr = 32'h24;
      #1;
      chk("ldpri_ld_gnt", bus.ld_gnt, 1);
      chk("ldpri_i_gnt", bus.i_gnt, 0);
      chk("ldpri_we_a", bus.ram_we_a, 1);
      model[8] = 32'hCAFEF00D;
      @(negedge clk); bus.ld_req = 0; #1;
      chk("ldpri_i_gnt_next", bus.i_gnt, 1);
      @(negedge clk); idle(); #1;
      chk("ldpri_i_rdata", bus.i_rdata, model[9]);

      // Full store and fetch to the same word, errors on port B.
      do_data(1, 4'b1111, 32'h08, 32'h5A5A0F0F, 1, 32'h08);
      do_data(0, 4'b0000, 32'h06, 32'h0, 0, 32'h0);
      do_data(1, 4'b1111, 32'h80, 32'h12345678, 0, 32'h0);
      chk("err_ram_w1", ram[1], model[1]);

      // Loader and load on the same word while port B is idle.
      @(negedge clk); idle();
      bus.ld_req = 1; bus.ld_addr = 32'h14; bus.ld_wdata = 32'h0BADC0DE;
      bus.d_req = 1; bus.d_addr = 32'h14;
      #1;
      chk("ldhaz_ld_gnt", bus.ld_gnt, 1);
      chk("ldhaz_d_gnt", bus.d_gnt, 0);
      model[5] = 32'h0BADC0DE;
      @(negedge clk); bus.ld_req = 0; #1;
      chk("ldhaz_d_gnt_next", bus.d_gnt, 1);
      @(negedge clk); idle(); #1;
      chk("ldhaz_d_rdata", bus.d_rdata, 32'h0BADC0DE);

      // Loader stalled during the RMW write of the same word.
      v = model[6];
      @(negedge clk); idle();
      bus.d_req = 1; bus.d_we = 1; bus.d_be = 4'b1000; bus.d_addr = 32'h18; bus.d_wdata = 32'h77000000;
      #1;
      chk("rmwld_d_gnt", bus.d_gnt, 1);
      @(negedge clk); idle();
      bus.ld_req = 1; bus.ld_addr = 32'h18; bus.ld_wdata = 32'h600DD00D;
      #1;
      chk("rmwld_ld_gnt", bus.ld_gnt, 0);
      chk("rmwld_we_a", bus.ram_we_a, 0);
      chk("rmwld_data_b", bus.ram_data_b, merge(v, 32'h77000000, 4'b1000));
      @(negedge clk); #1;
      chk("rmwld_ld_gnt_next", bus.ld_gnt, 1);
      chk("rmwld_ack", bus.d_rvalid, 1);
      model[6] = 32'h600DD00D;
      @(negedge clk); idle(); #1;
      chk("rmwld_word", ram[6], 32'h600DD00D);

      // Reset in the RMW write cycle drops the write.
      @(negedge clk); idle();
      bus.d_req = 1; bus.d_we = 1; bus.d_be = 4'b0011; bus.d_addr = 32'h0C; bus.d_wdata = 32'h12345678;
      #1;
      chk("rstrmw_d_gnt", bus.d_gnt, 1);
      @(negedge clk); idle(); rst = 1; #1;
      chk("rstrmw_we_b", bus.ram_we_b, 0);
      @(negedge clk); rst = 0; #1;
      chk("rstrmw_d_rvalid", bus.d_rvalid, 0);
      chk("rstrmw_d_err", bus.d_err, 0);
      chk("rstrmw_d_rdata", bus.d_rdata, 0);
      chk("rstrmw_i_rvalid", bus.i_rvalid, 0);
      chk("rstrmw_we_b_next", bus.ram_we_b, 0);
      chk("rstrmw_word", ram[3], 32'hDEADBEEF);
      do_data(0, 4'b0000, 32'h0C, 32'h0, 0, 32'h0);

      // Randomized port B traffic with concurrent fetches.
      for (int n = 0; n < 200; n++) begin
         r  = $urandom_range(0, 7);
         a  = AW'($urandom_range(0, NW - 1)) << 2;
         if (r == 0) a = a | AW'($urandom_range(1, 3));
         else if (r == 1) a = AW'($urandom_range(NW, 2 * NW - 1)) << 2;
         we = 1'($urandom_range(0, 1));
         be = BE_W'($urandom_range(0, 15));
         if ($urandom_range(0, 3) == 0) be = '1;
         wd = $urandom;
         fe = 1'($urandom_range(0, 1));
         fa = ($urandom_range(0, 2) == 0) ? a : (AW'($urandom_range(0, NW - 1)) << 2);
         if ($urandom_range(0, 9) == 0) fa = fa | AW'(1);
         do_data(we, be, a, wd, fe, fa);
      end

      repeat (2) @(negedge clk);
      for (int w = 0; w < NW; w++) chk("ram_word", ram[w], model[w]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Access controller in front of the shared dual-port instruction/data RAM.
- Port A serves instruction fetch; a boot loader may write through port A and has priority over fetch.
- Port B serves CPU load/store. Byte-enable stores are done as a read-modify-write (RMW), because the RAM only supports whole-word writes.
- Also handles grant/valid handshakes, misaligned and out-of-range errors, and cross-port same-address write hazards.

Parameters:
DATA_WIDTH, 32, word width; byte enables are DATA_WIDTH/8 wide.
ADDR_WIDTH, 32, byte address width on all request ports.
MEM_WORDS, 32, RAM depth in words; word index = addr[ADDR_WIDTH-1:2].

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
ld_req  in  1  loader write request
ld_addr  in  ADDR_WIDTH  loader byte address
ld_wdata  in  DATA_WIDTH  loader write word
ld_gnt  out  1  loader write accepted this cycle
i_req  in  1  fetch request
i_addr  in  ADDR_WIDTH  fetch byte address
i_gnt  out  1  fetch accepted this cycle
i_rvalid  out  1  fetch data valid (one cycle after i_gnt)
i_rdata  out  DATA_WIDTH  fetched word
i_err  out  1  fetch error, aligned with i_rvalid
d_req  in  1  data request
d_we  in  1  1 = store, 0 = load
d_be  in  DATA_WIDTH/8  store byte enables
d_addr  in  ADDR_WIDTH  data byte address
d_wdata  in  DATA_WIDTH  store data
d_gnt  out  1  data request accepted this cycle
d_rvalid  out  1  load data valid / store or error done
d_rdata  out  DATA_WIDTH  load word (0 for stores)
d_err  out  1  data error, aligned with d_rvalid
ram_addr_a, ram_addr_b  out  ADDR_WIDTH  RAM port addresses (byte addresses)
ram_we_a, ram_we_b  out  1  RAM write enables
ram_data_a, ram_data_b  out  DATA_WIDTH  RAM write data
ram_q_a, ram_q_b  in  DATA_WIDTH  RAM read data, registered: valid 1 cycle after the address is presented

Behaviour:
- Reset state: all gnt/rvalid/err outputs 0, ram_we_a/b 0, rdata outputs 0, port B FSM in IDLE, RMW holding registers cleared.
- Reset during RMW: the pending write is dropped and the RAM word keeps its old value.
- Handshake: the requester holds req/addr/data stable until gnt. gnt is combinational and lasts one cycle per transfer.
- Error checks, applied to every port:
  - addr[1:0] != 0 is misaligned.
  - word index >= MEM_WORDS is out of range.
  - An erroring request is granted, never reaches the RAM (we = 0), and pulses err with rvalid the next cycle, rdata = 0.
  - A loader request that errors is granted and dropped; there is no loader error output.
- Port A arbitration:
  - ld_req wins over i_req. With ld_req high: ld_gnt = 1, ram_we_a = 1, i_gnt = 0.
  - Otherwise an i_req is granted and i_rvalid/i_rdata = ram_q_a follow one cycle later.
  - Back-to-back fetches run at one per cycle.
- Port B FSM (states IDLE, RMW_WR):
  - IDLE, load: d_gnt = 1, read issued, d_rvalid = 1 next cycle with d_rdata = ram_q_b.
  - IDLE, store with be all-ones: d_gnt = 1, ram_we_b = 1, d_rvalid (ack) next cycle.
  - IDLE, store with be == 0: d_gnt = 1, no RAM write, ack next cycle.
  - IDLE, partial be: d_gnt = 1, read issued, addr/be/wdata latched, go to RMW_WR.
  - RMW_WR: merged = per byte (be[k] ? wdata byte k : ram_q_b byte k). Drive ram_we_b = 1 with merged at the latched address. d_gnt = 0 (new requests stall). Return to IDLE. Ack in the following cycle.
  - Throughput: a partial store occupies 2 cycles; all other data requests take 1.
- Cross-port hazards, compared on word index:
  - Port B write and port A fetch to the same word in the same cycle: i_gnt = 0 (fetch retries next cycle).
  - Loader write and any port B access to the same word in the same cycle: the loader wins; in IDLE d_gnt = 0. In RMW_WR, the loader is stalled (ld_gnt = 0) so the merge stays consistent.
- Simultaneous fetch and data access to different words both proceed in the same cycle.

Decomposition:
- Shared package mem_pkg holds:
  - port B FSM state enum (IDLE, RMW_WR);
  - BE_W = DATA_WIDTH/8;
  - WORD_IDX_W = $clog2(MEM_WORDS);
  - error-check function addr_ok(addr).
- One sub-module, byte_merge: combinational per-byte mux of old word, new word and be. All other logic stays in mem_ctrl.

Test Plan:
- Reset, then fetch 0x00, 0x04, 0x08 on consecutive cycles with the RAM preloaded with 0x11111111, 0x22222222, 0x33333333 -> i_gnt on 3 consecutive cycles, each i_rvalid one cycle later with the matching word, i_err = 0.
- Word 0x10 holds 0xAABBCCDD; store be=4'b0101, wdata=0x11223344 -> d_gnt then 1 stall cycle, RAM word = 0xAA22CC44, load of 0x10 returns 0xAA22CC44.
- ld_req to 0x20 and i_req to 0x24 in the same cycle -> ld_gnt = 1, i_gnt = 0; i_gnt = 1 the next cycle after ld_req drops.
- Full-word store to 0x08 with a fetch of 0x08 in the same cycle -> i_gnt = 0 that cycle; the fetch granted next cycle returns the stored value.
- d_addr 0x06 and d_addr 0x80 (MEM_WORDS = 32) -> each granted, d_err = d_rvalid = 1 next cycle, RAM unchanged, d_rdata = 0.
- rst asserted in RMW_WR cycle of a partial store to 0x0C (old 0xDEADBEEF) -> the RAM word stays 0xDEADBEEF and all outputs are 0 next cycle.
